// File: rtl/sqrt_task_scheduler_pkg.sv
// Shared types and constants for the sqrt task scheduler: worker lifecycle
// enum, default data width, worker-count ceiling and a priority-pick helper.
package sqrt_sched_pkg;

   localparam int W_DEF       = 32;
   localparam int MAX_WORKERS = 16;

   typedef enum logic [1:0] {
      W_FREE = 2'd0,
      W_BUSY = 2'd1,
      W_DONE = 2'd2
   } wstate_e;

   // Index of the lowest set bit; 0 when the mask is empty (caller gates on |mask).
   function automatic int lowest_set(input logic [MAX_WORKERS-1:0] m);
      int r;
      r = 0;
      for (int k = MAX_WORKERS - 1; k >= 0; k--) begin
         if (m[k]) r = k;
      end
      return r;
   endfunction

endpackage

// File: rtl/sqrt_task_scheduler_if.sv
// Bundle of upstream, worker-side and downstream signals of the scheduler.
// master = scheduler side, slave = environment (source, workers, sink).
interface sqrt_sched_if
   import sqrt_sched_pkg::*;
#(
   parameter int N_WORKERS = 4,
   parameter int W         = W_DEF
);
   logic                   arg_vld;
   logic                   arg_rdy;
   logic [W-1:0]           a;
   logic [W-1:0]           b;
   logic [W-1:0]           c;
   logic [N_WORKERS-1:0]   w_arg_vld;
   logic [W-1:0]           w_a;
   logic [W-1:0]           w_b;
   logic [W-1:0]           w_c;
   logic [N_WORKERS-1:0]   w_res_vld;
   logic [N_WORKERS*W-1:0] w_res;
   logic                   res_vld;
   logic [W-1:0]           res;

   modport master (
      input  arg_vld, a, b, c, w_res_vld, w_res,
      output arg_rdy, w_arg_vld, w_a, w_b, w_c, res_vld, res
   );

   modport slave (
      output arg_vld, a, b, c, w_res_vld, w_res,
      input  arg_rdy, w_arg_vld, w_a, w_b, w_c, res_vld, res
   );
endinterface

// File: rtl/sqrt_task_scheduler_order_fifo.sv
// Small FIFO remembering which worker got each accepted task, so results
// can be released in acceptance order. Any depth >= 2, not only powers of 2.
module sched_order_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_push_data,
   input  logic          i_pop,
   output logic          o_empty,
   output logic [DW-1:0] o_head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= ptr_inc(r_wr);
         if (i_pop)  r_rd <= ptr_inc(r_rd);
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   // Storage needs no reset; occupancy is tracked by r_cnt alone.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_push_data;
   end

   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/sqrt_task_scheduler.sv
// Dispatches argument triples to N_WORKERS external formula workers and
// returns results in acceptance order. Define SQRT_SCHED_ERR_CNT_EN to add
// the err_cnt port counting ignored (stray) completion pulses.
module sqrt_task_scheduler
   import sqrt_sched_pkg::*;
#(
   parameter int N_WORKERS = 4,   // legal 2..MAX_WORKERS
   parameter int W         = W_DEF
) (
   input  logic clk,
   input  logic rst,
   sqrt_sched_if.master bus
`ifdef SQRT_SCHED_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);
   localparam int IW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;

   wstate_e              r_state     [N_WORKERS];
   wstate_e              w_state_nxt [N_WORKERS];
   logic [W-1:0]         r_rslt      [N_WORKERS];

   logic [N_WORKERS-1:0] w_free;
   logic [N_WORKERS-1:0] w_cap;
   logic [N_WORKERS-1:0] w_onehot;
   logic                 w_acc;
   logic                 w_pop;
   logic                 w_empty;
   logic [IW-1:0]        w_sel;
   logic [IW-1:0]        w_head;

   logic [N_WORKERS-1:0] r_w_arg_vld;
   logic [W-1:0]         r_wa;
   logic [W-1:0]         r_wb;
   logic [W-1:0]         r_wc;
   logic                 r_res_vld;
   logic [W-1:0]         r_res;

   always_comb begin
      w_free = '0;
      w_cap  = '0;
      for (int i = 0; i < N_WORKERS; i++) begin
         w_free[i] = (r_state[i] == W_FREE);
         w_cap[i]  = bus.w_res_vld[i] && (r_state[i] == W_BUSY);
      end
   end

   // Ready depends on registered state only, so a worker freed this edge
   // is visible to upstream one cycle later.
   assign bus.arg_rdy = |w_free;
   assign w_acc       = bus.arg_vld && bus.arg_rdy;
   assign w_sel       = IW'(lowest_set(MAX_WORKERS'(w_free)));
   assign w_onehot    = N_WORKERS'(1) << w_sel;
   assign w_pop       = !w_empty && (r_state[w_head] == W_DONE);

   sched_order_fifo #(
      .DEPTH (N_WORKERS),
      .DW    (IW)
   ) u_order (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_acc),
      .i_push_data (w_sel),
      .i_pop       (w_pop),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   // Accept, capture and release each need a distinct current state,
   // so at most one of them can fire per worker in a cycle.
   always_comb begin
      for (int i = 0; i < N_WORKERS; i++) begin
         w_state_nxt[i] = r_state[i];
         if (w_acc && (w_sel == IW'(i)))  w_state_nxt[i] = W_BUSY;
         if (w_cap[i])                    w_state_nxt[i] = W_DONE;
         if (w_pop && (w_head == IW'(i))) w_state_nxt[i] = W_FREE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_WORKERS; i++) r_state[i] <= W_FREE;
      end else begin
         for (int i = 0; i < N_WORKERS; i++) r_state[i] <= w_state_nxt[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_WORKERS; i++) begin
         if (w_cap[i]) r_rslt[i] <= bus.w_res[i*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_arg_vld <= '0;
         r_wa        <= '0;
         r_wb        <= '0;
         r_wc        <= '0;
         r_res_vld   <= 1'b0;
         r_res       <= '0;
      end else begin
         r_w_arg_vld <= w_acc ? w_onehot : '0;
         if (w_acc) begin
            r_wa <= bus.a;
            r_wb <= bus.b;
            r_wc <= bus.c;
         end
         r_res_vld <= w_pop;
         if (w_pop) r_res <= r_rslt[w_head];
      end
   end

   assign bus.w_arg_vld = r_w_arg_vld;
   assign bus.w_a       = r_wa;
   assign bus.w_b       = r_wb;
   assign bus.w_c       = r_wc;
   assign bus.res_vld   = r_res_vld;
   assign bus.res       = r_res;

`ifdef SQRT_SCHED_ERR_CNT_EN
   logic [N_WORKERS-1:0] w_stray;
   logic [8:0]           w_err_sum;
   logic [7:0]           r_err_cnt;

   assign w_stray = bus.w_res_vld & ~w_cap;

   // Worst case 255 + MAX_WORKERS still fits in 9 bits before saturating.
   always_comb begin
      w_err_sum = {1'b0, r_err_cnt};
      for (int i = 0; i < N_WORKERS; i++) w_err_sum = w_err_sum + 9'(w_stray[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) r_err_cnt <= '0;
      else     r_err_cnt <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sqrt_task_scheduler.sv
// Randomised and directed bench for sqrt_task_scheduler with behavioural
// worker models and an in-order result scoreboard.
module tb_sqrt_task_scheduler;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
   } trip_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sqrt_sched_if #(.N_WORKERS(N), .W(W)) bus ();
`ifdef SQRT_SCHED_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   sqrt_task_scheduler #(.N_WORKERS(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SQRT_SCHED_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   trip_t        src_q[$];
   logic [W-1:0] exp_q[$];
   int           ord_q[$];
   int           res_cyc_q[$];
   int           acc_edge_q[$];
   int           mst [N];      // 0 free, 1 dispatched, 2 result held
   bit           acc_pend;
   int           acc_idx;
   trip_t        acc_trip;
   bit           pend [N];
   int           due  [N];
   logic [W-1:0] wval [N];
   int           lat  [N];
   bit           rand_lat;
   logic [N-1:0] stray;
   int           err_exp;
   bit           rst_cmd;
   bit           rst_prev;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
      logic [W-1:0] r;
      logic [W-1:0] t;
      r = '0;
      for (int k = W/2 - 1; k >= 0; k--) begin
         t = r | (W'(1) << k);
         if (64'(t) * 64'(t) <= 64'(x)) r = t;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] ref_f(input trip_t t);
      return isqrt(t.a) + (t.b ^ t.c);
   endfunction

   function automatic int n_pend();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) n += int'(pend[i]);
      return n;
   endfunction

   task automatic tick();
      logic [N-1:0] exp_oh;
      bit           any_free;
      bit           fire;
      int           w;
      int           l;
      trip_t        t;
      @(posedge clk);
      #1;
      cyc++;
      // ---- check phase: outputs of the cycle that just began
      if (rst_prev) begin
         chk("rst_arg_rdy", bus.arg_rdy, 1);
         chk("rst_res_vld", bus.res_vld, 0);
         chk("rst_res", bus.res, 0);
         chk("rst_w_arg_vld", bus.w_arg_vld, 0);
         chk("rst_w_abc", bus.w_a | bus.w_b | bus.w_c, 0);
         exp_q.delete();
         ord_q.delete();
         for (int i = 0; i < N; i++) mst[i] = 0;
         err_exp = 0;
      end else begin
         exp_oh = '0;
         if (acc_pend && acc_idx < N) exp_oh[acc_idx] = 1'b1;
         chk("w_arg_vld", bus.w_arg_vld, exp_oh);
         if (acc_pend) begin
            chk("w_a", bus.w_a, acc_trip.a);
            chk("w_b", bus.w_b, acc_trip.b);
            chk("w_c", bus.w_c, acc_trip.c);
         end
         if (bus.res_vld) begin
            if (exp_q.size() == 0) chk("res_vld_spurious", bus.res_vld, 0);
            else begin
               chk("res", bus.res, exp_q.pop_front());
               w = ord_q.pop_front();
               mst[w] = 0;
               res_cyc_q.push_back(cyc);
            end
         end
         any_free = 1'b0;
         for (int i = 0; i < N; i++) if (mst[i] == 0) any_free = 1'b1;
         chk("arg_rdy", bus.arg_rdy, any_free);
      end
`ifdef SQRT_SCHED_ERR_CNT_EN
      chk("err_cnt", err_cnt, err_exp);
`endif
      acc_pend = 1'b0;
      // ---- drive phase: inputs for this cycle
      rst      = rst_cmd;
      rst_prev = rst_cmd;
      for (int i = 0; i < N; i++) begin
         fire = pend[i] && (due[i] == cyc);
         bus.w_res_vld[i] = fire | stray[i];
         bus.w_res[i*W +: W] = fire ? wval[i] : W'($urandom);
         if (fire) pend[i] = 1'b0;
         if (!rst && (fire || stray[i])) begin
            if (mst[i] == 1) mst[i] = 2;
            else if (err_exp < 255) err_exp++;
         end
         if (bus.w_arg_vld[i]) begin
            l = rand_lat ? int'($urandom_range(1, 50)) : lat[i];
            t.a = bus.w_a; t.b = bus.w_b; t.c = bus.w_c;
            pend[i] = 1'b1;
            due[i]  = cyc + l + 1;
            wval[i] = ref_f(t);
         end
      end
      stray = '0;
      if (!rst && src_q.size() > 0) begin
         bus.arg_vld = 1'b1;
         bus.a = src_q[0].a;
         bus.b = src_q[0].b;
         bus.c = src_q[0].c;
         if (bus.arg_rdy) begin
            acc_pend = 1'b1;
            acc_trip = src_q.pop_front();
            acc_idx  = N;
            for (int i = N - 1; i >= 0; i--) if (mst[i] == 0) acc_idx = i;
            if (acc_idx < N) begin
               mst[acc_idx] = 1;
               ord_q.push_back(acc_idx);
            end
            exp_q.push_back(ref_f(acc_trip));
            acc_edge_q.push_back(cyc + 1);
         end
      end else begin
         bus.arg_vld = 1'b0;
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         bus.c = W'($urandom);
      end
   endtask

   task automatic run_idle(input int bound, input string tag);
      int k;
      k = 0;
      while ((src_q.size() + exp_q.size() + n_pend()) > 0 && k < bound) begin
         tick();
         k++;
      end
      if (k >= bound) chk({tag, "_drain"}, src_q.size() + exp_q.size() + n_pend(), 0);
      repeat (3) tick();
   endtask

   task automatic add_trips(input int n);
      trip_t t;
      for (int i = 0; i < n; i++) begin
         t.a = W'($urandom); t.b = W'($urandom); t.c = W'($urandom);
         src_q.push_back(t);
      end
   endtask

   task automatic clr_log();
      res_cyc_q.delete();
      acc_edge_q.delete();
   endtask

   task automatic do_reset();
      rst_cmd = 1'b1;
      tick();
      rst_cmd = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; rst_cmd = 1'b1; rst_prev = 1'b1;
      bus.arg_vld = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
      bus.w_res_vld = '0; bus.w_res = '0;
      stray = '0; rand_lat = 1'b0; acc_pend = 1'b0; acc_idx = 0; err_exp = 0;
      for (int i = 0; i < N; i++) begin
         mst[i] = 0; pend[i] = 1'b0; due[i] = 0; wval[i] = '0; lat[i] = 10;
      end
      repeat (3) tick();
      rst_cmd = 1'b0;
      repeat (2) tick();

      // back-to-back fill, fixed latency 10
      clr_log();
      add_trips(4);
      run_idle(300, "t1");
      chk("t1_count", res_cyc_q.size(), 4);
      if (res_cyc_q.size() > 0) chk("t1_latency", res_cyc_q[0] - acc_edge_q[0], 13);

      // out-of-order completion, in-order release
      clr_log();
      lat[0] = 30; lat[1] = 5;
      add_trips(2);
      run_idle(300, "t2");
      chk("t2_count", res_cyc_q.size(), 2);
      if (res_cyc_q.size() == 2) begin
         chk("t2_latency", res_cyc_q[0] - acc_edge_q[0], 33);
         chk("t2_gap", res_cyc_q[1] - res_cyc_q[0], 1);
      end

      // all busy with arg_vld held: 5th accept right after first release
      clr_log();
      for (int i = 0; i < N; i++) lat[i] = 10;
      add_trips(5);
      run_idle(300, "t3");
      chk("t3_count", res_cyc_q.size(), 5);
      if (res_cyc_q.size() == 5) chk("t3_acc5", acc_edge_q[4] - res_cyc_q[0], 1);

      // stray completion on an idle worker
      do_reset();
      clr_log();
      stray = 4'b0100;
      repeat (6) tick();
      chk("t4_no_res", res_cyc_q.size(), 0);
`ifdef SQRT_SCHED_ERR_CNT_EN
      chk("t4_err_cnt", err_cnt, 1);
`endif

      // reset with three tasks in flight; late completions must be dropped
      clr_log();
      for (int i = 0; i < N; i++) lat[i] = 20;
      add_trips(3);
      repeat (6) tick();
      do_reset();
      repeat (40) tick();
      chk("t5_no_res", res_cyc_q.size(), 0);
      chk("t5_arg_rdy", bus.arg_rdy, 1);
      run_idle(100, "t5");

      // random latency soak
      clr_log();
      rand_lat = 1'b1;
      add_trips(1000);
      run_idle(60000, "t6");
      chk("t6_count", res_cyc_q.size(), 1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sqrt_task_scheduler.md
SQRT_TASK_SCHEDULER -- requirements
Module: sqrt_task_scheduler

Interface
REQ-001 Parameter N_WORKERS, default 4, SHALL give the number of external FSM-based formula workers driven; legal range 2..16.
REQ-002 Parameter W, default 32, SHALL give the width of each argument and of the result.
REQ-003 clk  input  1  SHALL be the single rising-edge clock.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 arg_vld  input  1  SHALL mark a valid argument triple from upstream.
REQ-006 arg_rdy  output  1  SHALL signal that the scheduler accepts a triple this cycle.
REQ-007 a, b, c  input  W each  SHALL carry the argument triple.
REQ-008 w_arg_vld  output  N_WORKERS  SHALL be the one-hot start pulse to worker i.
REQ-009 w_a, w_b, w_c  output  W each  SHALL be the registered argument bus broadcast to all workers.
REQ-010 w_res_vld  input  N_WORKERS  SHALL carry the one-cycle completion pulse from worker i.
REQ-011 w_res  input  N_WORKERS*W  SHALL carry worker results, worker i in slice [i*W +: W].
REQ-012 res_vld  output  1  SHALL pulse for one cycle per delivered result; no downstream backpressure.
REQ-013 res  output  W  SHALL carry the result, valid only while res_vld=1.

Function
REQ-014 Each worker SHALL be in one of three states: FREE, BUSY (dispatched, no result), DONE (result captured, not yet delivered).
REQ-015 arg_rdy SHALL be 1 exactly when at least one worker is FREE; it SHALL be a function of registered state only, not of arg_vld.
REQ-016 Accept SHALL occur when arg_vld=1 and arg_rdy=1; the lowest-index FREE worker SHALL be selected.
REQ-017 On accept at edge T, the selected worker SHALL go FREE->BUSY, and on the cycle after T w_arg_vld[i]=1 with w_a/w_b/w_c holding the accepted triple.
REQ-018 w_arg_vld SHALL be all-zero on any cycle following a non-accept edge.
REQ-019 On each accept, the worker index SHALL be pushed into an order FIFO of depth N_WORKERS; the FIFO cannot overflow because pushes require a FREE worker.
REQ-020 w_res_vld[i]=1 while worker i is BUSY SHALL capture w_res slice i into a per-worker result register and move the worker to DONE.
REQ-021 w_res_vld[i]=1 while worker i is FREE or DONE SHALL be ignored; state and stored result are unchanged.
REQ-022 When the order FIFO is non-empty and its head worker is DONE at edge T, the scheduler SHALL pop the FIFO, set that worker FREE, and drive res_vld=1 with its stored result on the cycle after T.
REQ-023 At most one result SHALL be delivered per cycle. Results SHALL leave in acceptance order even if workers finish out of order.
REQ-024 A worker freed at edge T SHALL first count toward arg_rdy on the cycle after T; no same-cycle bypass.
REQ-025 Accept and delivery in the same cycle SHALL both take effect, including push and pop on the same FIFO.
REQ-026 A worker returning w_res_vld on the same edge as its head check SHALL be delivered one edge later (capture then deliver).
REQ-027 Minimum latency from accept edge to res_vld cycle SHALL be worker latency + 3 cycles.

Reset
REQ-028 On rst: all workers FREE, FIFO empty, arg_rdy=1 from the following cycle, w_arg_vld=0, res_vld=0, res=0, w_a/w_b/w_c=0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight tasks; worker completions arriving after reset SHALL be ignored per REQ-021.

Configuration
REQ-030 With macro SQRT_SCHED_ERR_CNT_EN defined, an extra output err_cnt [7:0] SHALL count ignored completion pulses (REQ-021), one per offending bit per cycle, saturating at 255, reset to 0.
REQ-031 Without SQRT_SCHED_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package sqrt_sched_pkg SHALL hold the worker-state enum (FREE/BUSY/DONE), the default W, and the maximum N_WORKERS constant.
REQ-033 The order FIFO SHALL be a sub-module sched_order_fifo (parameterised depth and width, push/pop/empty/head).

Verification
REQ-034 N_WORKERS=4, workers fixed at latency 10; 4 back-to-back triples → arg_rdy=0 on cycle 5; 4 results in order; first res_vld 13 cycles after the first accept.
REQ-035 Worker 0 latency 30, worker 1 latency 5; two triples → res of worker 1 held until worker 0's result leaves; res_vld on two consecutive cycles.
REQ-036 All 4 workers busy, arg_vld held at 1 → no accept until the cycle after the first delivery edge; the freed index is selected.
REQ-037 Stray w_res_vld[2] while worker 2 is FREE → no res_vld; with SQRT_SCHED_ERR_CNT_EN, err_cnt goes 0→1.
REQ-038 rst pulsed with 3 tasks in flight → res_vld stays 0 thereafter, arg_rdy=1, late completions ignored.
REQ-039 Random-latency workers (1..50) with continuous arg_vld for 1000 triples → scoreboard: every result delivered once, in order, with value matching the reference formula.
